result_reader: RTL and testbench

Drains the convolution result memory after a layer completes and streams each packed result word out as individual lanes over a valid/ready interface. It sits on the read port of the result memory and is started by the convolution controller's one-cycle `done` pulse. It produces one lane per accepted beat in address order, flags the final beat, and pulses `done` when the drain is complete.

---
 rtl/result_reader.sv | 126 ++++++++++++
 tb/tb_result_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// result_reader: drains the convolution result memory after a layer finishes
// and streams every packed result word out one lane per valid/ready beat.
module result_reader #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 4,
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 43,
    parameter int BASE_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [LANES*DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int WORD_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_WORDS - 1);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);
    localparam logic [ADDR_W-1:0]     BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_IDX_W-1:0]     word_idx_q, word_idx_d;
    logic [LANE_IDX_W-1:0]     lane_idx_q, lane_idx_d;
    logic [LANES*DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]         lane_data;

    // State, counters and the captured word; reset abandons any drain in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            lane_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            lane_idx_q <= lane_idx_d;
            word_q     <= word_d;
        end
    end

    // Select the lane currently being presented from the captured word.
    always_comb begin
        lane_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_idx_q == LANE_IDX_W'(i)) begin
                lane_data = word_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output decode; outputs are purely state-derived so a stall holds them.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        lane_idx_d = lane_idx_q;
        word_d     = word_q;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        out_data   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_idx_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = BASE + ADDR_W'(word_idx_q);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                word_d     = mem_rdata;
                lane_idx_d = '0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = lane_data;
                out_last  = (lane_idx_q == LAST_LANE) && (word_idx_q == LAST_WORD);
                if (out_ready) begin
                    if (lane_idx_q != LAST_LANE) begin
                        lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
                    end else if (word_idx_q != LAST_WORD) begin
                        word_idx_d = word_idx_q + WORD_IDX_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: one instance at the default size and a
// small one whose address range wraps past the top of a 4-bit memory.
module tb_result_reader;

   logic clock = 1'b0;
   logic resetN;

   // Free-running clock shared by both instances.
   always #5 clock = ~clock;

   logic        startA, memRdEnA, outValidA, outReadyA, outLastA, busyA, doneA;
   logic [7:0]  memAddrA;
   logic [31:0] memRdataA;
   logic [7:0]  outDataA;

   logic        startB, memRdEnB, outValidB, outReadyB, outLastB, busyB, doneB;
   logic [3:0]  memAddrB;
   logic [31:0] memRdataB;
   logic [7:0]  outDataB;

   result_reader dutA (
      .clk       (clock),
      .rst_n     (resetN),
      .start     (startA),
      .mem_rd_en (memRdEnA),
      .mem_addr  (memAddrA),
      .mem_rdata (memRdataA),
      .out_data  (outDataA),
      .out_valid (outValidA),
      .out_ready (outReadyA),
      .out_last  (outLastA),
      .busy      (busyA),
      .done      (doneA)
   );

   result_reader #(
      .DATA_W    (8),
      .LANES     (4),
      .ADDR_W    (4),
      .NUM_WORDS (4),
      .BASE_ADDR (14)
   ) dutB (
      .clk       (clock),
      .rst_n     (resetN),
      .start     (startB),
      .mem_rd_en (memRdEnB),
      .mem_addr  (memAddrB),
      .mem_rdata (memRdataB),
      .out_data  (outDataB),
      .out_valid (outValidB),
      .out_ready (outReadyB),
      .out_last  (outLastB),
      .busy      (busyB),
      .done      (doneB)
   );

   logic [31:0] memA [256];
   logic [31:0] memB [16];

   logic [8:0]  expBeatA [$];
   logic [7:0]  expAddrA [$];
   logic [8:0]  expBeatB [$];
   logic [3:0]  expAddrB [$];

   int testsRun = 0;
   int testsFailed = 0;

   int busyCyclesA = 0;
   int doneCountA = 0;
   int doneAtA = 0;
   int lastBeatAtA = 0;
   int beatsA = 0;
   logic prevStallA = 1'b0;
   logic [8:0] prevBeatA = '0;
   int doneCountB = 0;

   // Result memories with one cycle of read latency.
   always @(posedge clock) begin
      if (memRdEnA) memRdataA <= memA[memAddrA];
      if (memRdEnB) memRdataB <= memB[memAddrB];
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Monitor for the default instance: scoreboard, stall stability, cycle bookkeeping.
   always @(negedge clock) begin
      if (!resetN) begin
         prevStallA <= 1'b0;
      end else begin
         if (busyA) busyCyclesA <= busyCyclesA + 1;
         if (doneA) begin
            doneCountA <= doneCountA + 1;
            doneAtA    <= busyCyclesA + 1;
         end
         if (prevStallA) begin
            checkOutput("stall_valid", 32'(outValidA), 32'd1);
            checkOutput("stall_beat", 32'({outLastA, outDataA}), 32'(prevBeatA));
         end
         prevStallA <= outValidA && !outReadyA;
         prevBeatA  <= {outLastA, outDataA};
         if (outValidA && outReadyA) begin
            beatsA <= beatsA + 1;
            if (outLastA) lastBeatAtA <= busyCyclesA + 1;
            checkOutput("beat_pending", 32'(expBeatA.size() > 0), 32'd1);
            if (expBeatA.size() > 0)
               checkOutput("beat", 32'({outLastA, outDataA}), 32'(expBeatA.pop_front()));
         end
         if (memRdEnA) begin
            checkOutput("rd_while_streaming", 32'(outValidA), 32'd0);
            checkOutput("addr_pending", 32'(expAddrA.size() > 0), 32'd1);
            if (expAddrA.size() > 0)
               checkOutput("mem_addr", 32'(memAddrA), 32'(expAddrA.pop_front()));
         end
      end
   end

   // Monitor for the wrapping instance.
   always @(negedge clock) begin
      if (resetN) begin
         if (doneB) doneCountB <= doneCountB + 1;
         if (outValidB && outReadyB) begin
            checkOutput("b_beat_pending", 32'(expBeatB.size() > 0), 32'd1);
            if (expBeatB.size() > 0)
               checkOutput("b_beat", 32'({outLastB, outDataB}), 32'(expBeatB.pop_front()));
         end
         if (memRdEnB) begin
            checkOutput("b_addr_pending", 32'(expAddrB.size() > 0), 32'd1);
            if (expAddrB.size() > 0)
               checkOutput("b_mem_addr", 32'(memAddrB), 32'(expAddrB.pop_front()));
         end
      end
   end

   // Push the expected drain for one instance, then pulse its start for one edge.
   task automatic applyStimulus(input logic selB);
      logic        lastBeat;
      int          addr;
      if (!selB) begin
         for (int w = 0; w < 43; w++) begin
            expAddrA.push_back(8'(w));
            for (int l = 0; l < 4; l++) begin
               lastBeat = (w == 42) && (l == 3);
               expBeatA.push_back({lastBeat, 8'(4 * w + l + 1)});
            end
         end
         startA = 1'b1;
      end else begin
         for (int w = 0; w < 4; w++) begin
            addr = (14 + w) % 16;
            expAddrB.push_back(4'(addr));
            for (int l = 0; l < 4; l++) begin
               lastBeat = (w == 3) && (l == 3);
               expBeatB.push_back({lastBeat, 8'(128 + 4 * addr + l)});
            end
         end
         startB = 1'b1;
      end
      @(posedge clock);
      #1;
      startA = 1'b0;
      startB = 1'b0;
   endtask

   task automatic checkIdleA(input string ctx);
      checkOutput({ctx, "_rd_en"}, 32'(memRdEnA), 32'd0);
      checkOutput({ctx, "_addr"}, 32'(memAddrA), 32'd0);
      checkOutput({ctx, "_data"}, 32'(outDataA), 32'd0);
      checkOutput({ctx, "_valid"}, 32'(outValidA), 32'd0);
      checkOutput({ctx, "_last"}, 32'(outLastA), 32'd0);
      checkOutput({ctx, "_busy"}, 32'(busyA), 32'd0);
      checkOutput({ctx, "_done"}, 32'(doneA), 32'd0);
   endtask

   // Run one full drain on the default instance; mode 1 applies 1,0,0 backpressure.
   task automatic runDrainA(input int mode, input int ignoreAt, output int busyBase);
      int doneBase;
      int beatBase;
      int cyc;
      doneBase  = doneCountA;
      beatBase  = beatsA;
      outReadyA = 1'b1;
      applyStimulus(1'b0);
      busyBase = busyCyclesA;
      cyc = 0;
      while (doneCountA == doneBase && cyc < 5000) begin
         outReadyA = (mode == 0) || (cyc % 3 == 0);
         startA    = (cyc == ignoreAt);
         @(posedge clock);
         #1;
         cyc++;
      end
      startA    = 1'b0;
      outReadyA = 1'b1;
      checkOutput("done_pulses", 32'(doneCountA - doneBase), 32'd1);
      checkOutput("busy_after_done", 32'(busyA), 32'd0);
      checkOutput("done_one_cycle", 32'(doneA), 32'd0);
      checkOutput("beat_count", 32'(beatsA - beatBase), 32'd172);
      checkOutput("done_after_last", 32'(doneAtA - lastBeatAtA), 32'd1);
      checkOutput("beats_left", 32'(expBeatA.size()), 32'd0);
      checkOutput("addrs_left", 32'(expAddrA.size()), 32'd0);
      @(posedge clock);
      #1;
      checkOutput("no_restart", 32'(busyA), 32'd0);
   endtask

   initial begin
      int base;
      int beatBase;
      int doneBase;
      int cyc;

      for (int i = 0; i < 256; i++)
         memA[i] = {8'(4 * i + 4), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1)};
      for (int a = 0; a < 16; a++)
         memB[a] = {8'(128 + 4 * a + 3), 8'(128 + 4 * a + 2), 8'(128 + 4 * a + 1), 8'(128 + 4 * a)};

      startA = 1'b0; startB = 1'b0;
      outReadyA = 1'b1; outReadyB = 1'b1;
      resetN = 1'b1;
      #1 resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkIdleA("reset");
      resetN = 1'b1;
      @(posedge clock);
      #1;

      $display("[TB] full drain at defaults, sink always ready");
      runDrainA(0, -1, base);
      checkOutput("busy_cycles", 32'(doneAtA - base), 32'd259);

      $display("[TB] drain with backpressure and a stray start");
      runDrainA(1, 100, base);

      $display("[TB] reset during word 20");
      outReadyA = 1'b1;
      beatBase  = beatsA;
      applyStimulus(1'b0);
      cyc = 0;
      while (beatsA - beatBase < 81 && cyc < 1000) begin
         @(negedge clock);
         #1;
         cyc++;
      end
      checkOutput("pre_reset_valid", 32'(outValidA), 32'd1);
      resetN = 1'b0;
      #1;
      checkIdleA("midreset");
      expBeatA.delete();
      expAddrA.delete();
      repeat (2) @(posedge clock);
      #1;
      resetN = 1'b1;
      @(posedge clock);
      #1;
      runDrainA(0, -1, base);
      checkOutput("busy_cycles_rerun", 32'(doneAtA - base), 32'd259);

      $display("[TB] address wrap instance");
      doneBase = doneCountB;
      applyStimulus(1'b1);
      cyc = 0;
      while (doneCountB == doneBase && cyc < 200) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      checkOutput("b_done_pulses", 32'(doneCountB - doneBase), 32'd1);
      checkOutput("b_busy_after_done", 32'(busyB), 32'd0);
      checkOutput("b_beats_left", 32'(expBeatB.size()), 32'd0);
      checkOutput("b_addrs_left", 32'(expAddrB.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
